// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_stall_ctrl #(
    parameter int DMEM_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_use_stall,
    input  logic             i_redirect_ex,
    input  logic [31:0]      i_target_ex,
    input  logic             i_redirect_id,
    input  logic [31:0]      i_target_id,
    input  logic             i_imem_ready,
    input  logic             i_dmem_req_mem,
    input  logic             i_dmem_ready,
    output logic             o_pc_we,
    output logic             o_pc_sel,
    output logic [31:0]      o_pc_target,
    output logic             o_if_id_we,
    output logic             o_if_id_flush,
    output logic             o_id_ex_we,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_we,
    output logic             o_mem_wb_we,
    output logic             o_mem_wb_flush,
    output logic             o_redirect_pend,
    output logic             o_halted,
    output logic             o_bus_err,
    output logic [CNT_W-1:0] o_stall_cycles
);
    localparam int DW = $clog2(DMEM_TIMEOUT);

    typedef enum logic [1:0] {S_RUN, S_PEND, S_HALT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_pend_target;
    logic [31:0]       w_pend_nxt;
    logic [DW-1:0]     r_dwait_cnt;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic              r_bus_err;
    logic              w_mem_stall;
    logic              w_dwait_run;
    logic              w_timeout;
    logic [31:0]       w_tgt;

    assign w_mem_stall     = i_dmem_req_mem & ~i_dmem_ready;
    assign w_tgt           = i_redirect_ex ? i_target_ex : i_target_id;
    assign o_redirect_pend = (r_state == S_PEND);
    assign o_halted        = (r_state == S_HALT);
    assign o_bus_err       = r_bus_err;
    assign o_stall_cycles  = r_stall_cycles;

    always_comb begin
        o_pc_we        = 1'b1;
        o_pc_sel       = 1'b0;
        o_pc_target    = '0;
        o_if_id_we     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_we     = 1'b1;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_we    = 1'b1;
        o_mem_wb_we    = 1'b1;
        o_mem_wb_flush = 1'b0;
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend_target;
        w_dwait_run    = 1'b0;
        w_timeout      = 1'b0;
        if (i_rst) begin
            {o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_mem_wb_we} = '0;
            {o_if_id_flush, o_id_ex_flush, o_mem_wb_flush}               = '1;
        end else if (r_state == S_HALT) begin
            {o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_mem_wb_we} = '0;
        end else if (w_mem_stall) begin
            {o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_mem_wb_we} = '0;
            o_mem_wb_flush = 1'b1;
            w_dwait_run    = 1'b1;
            if (r_dwait_cnt == DW'(DMEM_TIMEOUT - 1)) begin
                w_timeout   = 1'b1;
                w_state_nxt = S_HALT;
            end
        end else if (i_load_use_stall) begin
            o_pc_we       = 1'b0;
            o_if_id_we    = 1'b0;
            o_id_ex_flush = 1'b1;
        end else if (r_state == S_RUN && (i_redirect_ex || i_redirect_id)) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = i_redirect_ex;
            if (i_imem_ready) begin
                o_pc_sel    = 1'b1;
                o_pc_target = w_tgt;
            end else begin
                o_pc_we     = 1'b0;
                w_pend_nxt  = w_tgt;
                w_state_nxt = S_PEND;
            end
        end else if (r_state == S_PEND) begin
            // The fetch in flight belongs to the wrong path; wait it out, then jump.
            o_if_id_flush = 1'b1;
            if (i_redirect_ex) begin
                o_id_ex_flush = 1'b1;
                w_pend_nxt    = i_target_ex;
            end
            if (i_imem_ready) begin
                o_pc_sel    = 1'b1;
                o_pc_target = i_redirect_ex ? i_target_ex : r_pend_target;
                w_state_nxt = S_RUN;
            end else begin
                o_pc_we = 1'b0;
            end
        end else if (!i_imem_ready) begin
            o_pc_we       = 1'b0;
            o_if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_RUN;
            r_pend_target  <= '0;
            r_dwait_cnt    <= '0;
            r_stall_cycles <= '0;
            r_bus_err      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend_target <= w_pend_nxt;
            r_dwait_cnt   <= w_dwait_run ? r_dwait_cnt + DW'(1) : '0;
            r_bus_err     <= w_timeout;
            if (r_state != S_HALT && !o_pc_we && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end
endmodule
